nibble_display_scan: RTL and testbench

Multiplexed four-digit seven-segment driver that consumes the processor's architectural outputs (Out0, Out1, Out2, Accu, C, Z) and scans them onto a common-anode display. It sits directly downstream of the processor board. It snapshots all inputs once per frame so a digit never tears mid-scan. It inserts a blanking interval before each digit to suppress ghosting.

---
 rtl/display_pkg.sv | 45 ++++
 rtl/hex_to_seg7.sv | 21 ++
 rtl/nibble_display_scan.sv | 194 +++++++++++++++++++
 tb/tb_nibble_display_scan.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared types and constants for the seven-segment scan driver.
//   - scan_state_t : scan FSM states (IDLE, BLANK, DRIVE)
//   - snap_t       : frame snapshot of the processor's architectural outputs
//   - SEG_BLANK    : all segments off (active-low)
//   - AN_OFF       : all anodes off (active-low)
//   - HEX_SEG      : 16-entry hex -> {g,f,e,d,c,b,a} active-low pattern table
// -----------------------------------------------------------------------------
package display_pkg;

   localparam int unsigned NIB_W = 4;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   typedef struct packed {
      logic [NIB_W-1:0] out0;
      logic [NIB_W-1:0] out1;
      logic [NIB_W-1:0] out2;
      logic [NIB_W-1:0] accu;
      logic             c;
      logic             z;
   } snap_t;

   // Entry 15 first so that HEX_SEG[v] yields the pattern for value v.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   // Active-low one-hot anode pattern for the given digit index.
   function automatic logic [3:0] an_for_digit(input logic [1:0] digit);
      return ~(4'b0001 << digit);
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
//   Combinational hex-digit to seven-segment decoder, active-low outputs.
//   Ports:
//     i_nib  [N-1:0] : nibble to display
//     o_seg  [6:0]   : segment pattern {g,f,e,d,c,b,a}, low = segment lit
// -----------------------------------------------------------------------------
module hex_to_seg7
   import display_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] i_nib,
   output logic [6:0]   o_seg
);

   always_comb begin
      o_seg = HEX_SEG[i_nib];
   end

endmodule

// File: rtl/nibble_display_scan.sv
// -----------------------------------------------------------------------------
// nibble_display_scan
//   Four-digit multiplexed common-anode seven-segment driver for the
//   processor's Out0/Out1/Out2/Accu ports and C/Z flags. Inputs are captured
//   once per frame into a snapshot so a digit never changes mid-scan; each
//   digit slot begins with BLANK_CYC dark cycles to suppress ghosting.
//   Ports:
//     clk              : clock, all state on rising edge
//     reset            : asynchronous active-low reset
//     en               : scan enable; low = dark outputs, all state held
//     Out0/Out1/Out2   : [N-1:0] shown on digits 0, 1, 2
//     Accu             : [N-1:0] shown on digit 3
//     C, Z             : flags; C lights dp on digit 3, Z lights dp on digit 2
//     seg [6:0]        : segments {g,f,e,d,c,b,a}, active-low, registered
//     dp               : decimal point, active-low, registered
//     an  [3:0]        : digit anodes, active-low, registered
// -----------------------------------------------------------------------------
module nibble_display_scan
   import display_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned DIV       = 50000,
   parameter int unsigned BLANK_CYC = 500
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] Out0,
   input  logic [N-1:0] Out1,
   input  logic [N-1:0] Out2,
   input  logic [N-1:0] Accu,
   input  logic         C,
   input  logic         Z,
   output logic [6:0]   seg,
   output logic         dp,
   output logic [3:0]   an
);

   localparam int unsigned CW      = $clog2(DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   // Without a blanking interval the first slot starts lit straight from IDLE.
   localparam scan_state_t FIRST_STATE = (BLANK_CYC == 0) ? DRIVE : BLANK;

   scan_state_t   r_state;
   scan_state_t   w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_cnt_inc;
   logic          w_cnt_wrap;
   logic          w_inc_blank;
   logic [1:0]    r_digit;
   logic [1:0]    w_digit_nxt;
   snap_t         r_snap;
   snap_t         w_snap_in;
   logic          w_snap_ld;
   logic [N-1:0]  w_nib;
   logic [6:0]    w_seg_dec;
   logic [3:0]    w_an_nxt;
   logic [6:0]    w_seg_nxt;
   logic          w_dp_nxt;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_dp;

   // Prescaler step and whether the stepped count lands in the blank window.
   assign w_cnt_wrap = (r_cnt == CNT_MAX);
   assign w_cnt_inc  = w_cnt_wrap ? '0 : r_cnt + 1'b1;

   generate
      if (BLANK_CYC == 0) begin : g_no_blank
         assign w_inc_blank = 1'b0;
      end else begin : g_blank
         localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
         assign w_inc_blank = (w_cnt_inc < BLANK_LIM);
      end
   endgenerate

   always_comb begin
      w_snap_in      = '0;
      w_snap_in.out0 = Out0;
      w_snap_in.out1 = Out1;
      w_snap_in.out2 = Out2;
      w_snap_in.accu = Accu;
      w_snap_in.c    = C;
      w_snap_in.z    = Z;
   end

   // ---------------------------------------------------------------------------
   // Scan FSM: next state, prescaler, digit index and snapshot load strobe.
   // Everything holds while en is low.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_digit_nxt = r_digit;
      w_snap_ld   = 1'b0;
      if (en) begin
         case (r_state)
            IDLE: begin
               w_snap_ld   = 1'b1;
               w_cnt_nxt   = '0;
               w_digit_nxt = '0;
               w_state_nxt = FIRST_STATE;
            end
            BLANK, DRIVE: begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_wrap) begin
                  w_digit_nxt = r_digit + 2'd1;
                  // Frame wrap: capture inputs for the next four slots.
                  w_snap_ld   = (r_digit == 2'd3);
               end
               w_state_nxt = w_inc_blank ? BLANK : DRIVE;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_digit <= '0;
         r_snap  <= '0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_digit <= w_digit_nxt;
         if (w_snap_ld) begin
            r_snap <= w_snap_in;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Digit mux feeding a single decoder.
   // ---------------------------------------------------------------------------
   always_comb begin
      case (r_digit)
         2'd0:    w_nib = r_snap.out0;
         2'd1:    w_nib = r_snap.out1;
         2'd2:    w_nib = r_snap.out2;
         default: w_nib = r_snap.accu;
      endcase
   end

   hex_to_seg7 #(
      .N (N)
   ) u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg_dec)
   );

   // ---------------------------------------------------------------------------
   // Output register inputs: lit only while driving and enabled.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_an_nxt  = AN_OFF;
      w_seg_nxt = SEG_BLANK;
      w_dp_nxt  = 1'b1;
      if (en && (r_state == DRIVE)) begin
         w_an_nxt  = an_for_digit(r_digit);
         w_seg_nxt = w_seg_dec;
         w_dp_nxt  = ~(((r_digit == 2'd3) && r_snap.c) ||
                       ((r_digit == 2'd2) && r_snap.z));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_an  <= AN_OFF;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;

endmodule

// File: tb/tb_nibble_display_scan.sv
`timescale 1ns/1ps
module tb_nibble_display_scan;

   localparam int unsigned DIV  = 8;
   localparam int unsigned BC   = 2;
   localparam int unsigned NONE = 9999;
   localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

   logic       clk = 1'b0;
   logic       rst_n, rst0_n, en;
   logic [3:0] o0, o1, o2, ac;
   logic       c, z;
   logic [6:0] seg, seg0;
   logic       dp, dp0;
   logic [3:0] an, an0;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;
   int unsigned edge_n = 0;
   int unsigned base;

   logic [11:0] qa[$];
   logic [11:0] q0[$];

   always #5 clk = ~clk;

   nibble_display_scan #(.N(4), .DIV(DIV), .BLANK_CYC(BC)) dut (
      .clk(clk), .reset(rst_n), .en(en),
      .Out0(o0), .Out1(o1), .Out2(o2), .Accu(ac), .C(c), .Z(z),
      .seg(seg), .dp(dp), .an(an)
   );

   nibble_display_scan #(.N(4), .DIV(DIV), .BLANK_CYC(0)) dut0 (
      .clk(clk), .reset(rst0_n), .en(en),
      .Out0(o0), .Out1(o1), .Out2(o2), .Accu(ac), .C(c), .Z(z),
      .seg(seg0), .dp(dp0), .an(an0)
   );

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic push_e(input bit sel, input logic [11:0] e);
      if (sel) q0.push_back(e);
      else     qa.push_back(e);
   endtask

   // Expected pin values for one full frame; optionally inserts gate_len dark
   // cycles ahead of slot position gate_at (enable dropped, scan held).
   task automatic push_frame(input bit sel, input int unsigned blank,
                             input logic [3:0] n0, input logic [3:0] n1,
                             input logic [3:0] n2, input logic [3:0] n3,
                             input logic fc, input logic fz,
                             input int unsigned gate_at, input int unsigned gate_len);
      logic [3:0]  nib [4];
      logic [3:0]  an_e;
      logic        dp_e;
      int unsigned d, cc;
      nib[0] = n0; nib[1] = n1; nib[2] = n2; nib[3] = n3;
      for (int unsigned i = 0; i < 4 * DIV; i++) begin
         if (i == gate_at) begin
            for (int unsigned g = 0; g < gate_len; g++) push_e(sel, DARK);
         end
         d  = i / DIV;
         cc = i % DIV;
         if (cc < blank) begin
            push_e(sel, DARK);
         end else begin
            an_e    = 4'hF;
            an_e[d] = 1'b0;
            dp_e    = !(((d == 3) && fc) || ((d == 2) && fz));
            push_e(sel, {an_e, hex7(nib[d]), dp_e});
         end
      end
   endtask

   task automatic consume_to(input int unsigned k);
      logic [11:0] e;
      while (edge_n < k) begin
         @(posedge clk);
         #1;
         edge_n++;
         if (qa.size() > 0) begin
            e = qa.pop_front();
            chk($sformatf("scanA@%0d", edge_n), {an, seg, dp}, e);
         end
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk($sformatf("scan0@%0d", edge_n), {an0, seg0, dp0}, e);
         end
         chk("ovlA", {11'd0, ($countones(~an) <= 1)}, 12'd1);
         chk("ovl0", {11'd0, ($countones(~an0) <= 1)}, 12'd1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst0_n = 1'b0; en = 1'b1;
      o0 = 4'h3; o1 = 4'h0; o2 = 4'h0; ac = 4'h0; c = 1'b0; z = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rstA", {an, seg, dp}, DARK);
      chk("rst0", {an0, seg0, dp0}, DARK);

      // Reset release: one IDLE cycle, then frame 1 with Out0=3.
      push_e(0, DARK);
      push_frame(0, BC, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, NONE, 0);
      rst_n  = 1'b1;
      edge_n = 0;
      consume_to(10);

      // Full-frame values applied mid frame 1; visible from frame 2.
      o0 = 4'h1; o1 = 4'hA; o2 = 4'h8; ac = 4'hF; c = 1'b1; z = 1'b0;
      push_frame(0, BC, 4'h1, 4'hA, 4'h8, 4'hF, 1'b1, 1'b0, NONE, 0);
      consume_to(45);

      // Accu=2 for frame 3.
      ac = 4'h2;
      push_frame(0, BC, 4'h1, 4'hA, 4'h8, 4'h2, 1'b1, 1'b0, NONE, 0);
      consume_to(77);

      // Digit 1 is lit now: Accu change must wait for frame 4.
      // Frame 4 also sees en dropped for 5 clks mid digit 2.
      ac = 4'h7;
      push_frame(0, BC, 4'h1, 4'hA, 4'h8, 4'h7, 1'b1, 1'b0, 20, 5);
      consume_to(117);
      en = 1'b0;
      consume_to(122);
      en = 1'b1;
      consume_to(134);

      // Frame 5; async reset while digit 2 is lit.
      push_frame(0, BC, 4'h1, 4'hA, 4'h8, 4'h7, 1'b1, 1'b0, NONE, 0);
      consume_to(154);
      chk("an_pre_rst", {8'd0, an}, 12'h00B);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {an, seg, dp}, DARK);
      qa.delete();
      consume_to(156);
      chk("rst_hold", {an, seg, dp}, DARK);

      // Release again: snapshot reloads from IDLE.
      push_e(0, DARK);
      push_frame(0, BC, 4'h1, 4'hA, 4'h8, 4'h7, 1'b1, 1'b0, NONE, 0);
      rst_n = 1'b1;
      base  = edge_n;
      consume_to(base + 33);

      // No-blank variant: lit 2 clks after release, no dark cycle between slots.
      push_e(1, DARK);
      push_frame(1, 0, 4'h1, 4'hA, 4'h8, 4'h7, 1'b1, 1'b0, NONE, 0);
      rst0_n = 1'b1;
      base   = edge_n;
      consume_to(base + 33);

      chk("qa_empty", 12'(qa.size()), 12'd0);
      chk("q0_empty", 12'(q0.size()), 12'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
